bram_reader: RTL and testbench
==============================

BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, word count of the attached BRAM; localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports start (input, 1, one-cycle request pulse), base (input, ADDR_WIDTH, first address) and len (input, ADDR_WIDTH+1, word count 0..DEPTH).
REQ-006 SHALL have ports busy (output, 1, transfer in progress), done (output, 1, one-cycle completion pulse) and err (output, 1, one-cycle rejection pulse).
REQ-007 SHALL have BRAM-side ports bram_en, bram_we (output, 1), bram_addr (output, ADDR_WIDTH), bram_dout (input, WIDTH) and bram_ready (input, 1), driving one port of a single-cycle-latency BRAM.
REQ-008 SHALL have stream ports out_valid (output, 1), out_ready (input, 1), out_data (output, WIDTH) and out_last (output, 1, marks the final word).

Function
REQ-009 SHALL implement the FSM states IDLE, RUN and DRAIN; start is sampled only in IDLE and ignored otherwise.
REQ-010 SHALL, on start in IDLE with len>0, latch base/len, enter RUN and assert busy from the next cycle.
REQ-011 SHALL, on start with len=0, stay in IDLE, issue no reads and pulse done the next cycle.
REQ-012 SHALL drive bram_we constantly 0 and bram_addr = base+issued; bram_en high only in RUN with issue credit.
REQ-013 SHALL grant issue credit when buffered + in_flight - pop < 2 (pop = out_valid & out_ready in the same cycle).
REQ-014 SHALL write bram_dout into a 2-entry skid FIFO on every cycle bram_ready is high; the FIFO never overflows.
REQ-015 SHALL drive out_valid = FIFO non-empty and out_data = FIFO head; out_data stays stable while out_valid & !out_ready.
REQ-016 SHALL assert out_last with the word whose index is len-1.
REQ-017 SHALL give latency start at edge k -> bram_en in cycle k+1 -> out_valid in cycle k+3, and sustain 1 word/cycle while out_ready=1.
REQ-018 SHALL go RUN -> DRAIN after issuing len reads and DRAIN -> IDLE when the last word pops; done pulses in the following cycle, busy falls with it.
REQ-019 SHALL tolerate out_ready held low indefinitely without losing, duplicating or reordering words.

Reset
REQ-020 SHALL, on rst_n low at any time (including mid-transfer), force IDLE, empty the FIFO, clear counters, and drive busy, done, err, bram_en, out_valid and out_last to 0.
REQ-021 SHALL discard any bram_ready arriving in the first cycle after reset release.

Configuration
REQ-022 SHALL, with BRAM_READER_WRAP_EN defined, wrap addresses modulo DEPTH (base+len > DEPTH allowed) and tie err to 0.
REQ-023 SHALL, without BRAM_READER_WRAP_EN, reject start with base+len > DEPTH: stay IDLE, issue no reads, pulse err the next cycle with no done.

Structure
REQ-024 SHALL place the FSM state enum and the skid depth constant (2) in shared package bram_pkg.
REQ-025 SHALL implement the skid FIFO as sub-module bram_skid_fifo (2 entries, push/pop/full/empty).

Verification
REQ-026 SHALL cover: WIDTH=8, DEPTH=16, BRAM preloaded mem[i]=i+0x10, base=2, len=4, out_ready=1 -> 0x12,0x13,0x14,0x15 on consecutive cycles, out_last on 0x15, first out_valid 3 cycles after start.
REQ-027 SHALL cover: same transfer with out_ready toggling 1,0,0,1,... -> the same four words in order, none lost or duplicated, FIFO occupancy never above 2.
REQ-028 SHALL cover: len=0 -> no bram_en, done 1 cycle after start, busy never high.
REQ-029 SHALL cover: base=14, len=4 -> with macro, words 0x1E,0x1F,0x10,0x11; without macro, err pulse and no bram_en.
REQ-030 SHALL cover: rst_n low after the 2nd output word -> all outputs 0 while reset is held; a new start after release with base=0, len=2 -> 0x10,0x11.
REQ-031 SHALL cover: start pulsed while busy -> ignored; the current transfer completes unchanged with a single done.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM reader: FSM state encoding and skid-buffer depth.
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bram_state_e;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/bram_skid_fifo.sv
// Two-entry skid buffer between the BRAM read port and the output stream.
// A push while full is only accepted when the same cycle also pops.
module bram_skid_fifo
    import bram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    // Pointers wrap naturally because SKID_DEPTH is a power of two.
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(SKID_DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/bram_reader.sv
// Streams len words from a single-cycle-latency BRAM starting at base, with backpressure.
// Define BRAM_READER_WRAP_EN to wrap addresses modulo DEPTH instead of rejecting overruns.
module bram_reader
    import bram_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int DEPTH      = 1024,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [WIDTH-1:0]      bram_dout,
    input  logic                  bram_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last
);
    bram_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH:0]   popped_q;
    logic [1:0]            inFlight_q;
    logic                  armed_q;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  issue;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  retire;
    logic                  credit;
    logic                  reject;
    logic                  zeroLen;
    logic                  lastIssue;
    logic                  lastWord;
    logic [ADDR_WIDTH:0]   lenM1;
    logic [1:0]            occupancy;
    logic                  fifoFull;
    logic                  fifoEmpty;

    assign zeroLen   = (len == '0);
    assign lenM1     = len_q - (ADDR_WIDTH+1)'(1);
    assign lastIssue = (issued_q == lenM1);
    assign lastWord  = (popped_q == lenM1);

    // armed_q is low for the first cycle after reset so a stale BRAM response is dropped.
    assign push      = bram_ready && armed_q;
    assign pop       = !fifoEmpty && out_ready;
    assign retire    = push && (inFlight_q != 2'd0);
    assign occupancy = {fifoFull, !fifoFull && !fifoEmpty};
    assign credit    = (3'(occupancy) + 3'(inFlight_q)) < (3'(SKID_DEPTH) + 3'(pop));

`ifdef BRAM_READER_WRAP_EN
    logic [ADDR_WIDTH:0] addrSum;

    assign reject    = 1'b0;
    assign addrSum   = {1'b0, base_q} + issued_q;
    assign bram_addr = (addrSum >= (ADDR_WIDTH+1)'(DEPTH))
                     ? ADDR_WIDTH'(addrSum - (ADDR_WIDTH+1)'(DEPTH))
                     : addrSum[ADDR_WIDTH-1:0];
`else
    logic [ADDR_WIDTH+1:0] endAddr;

    assign endAddr   = (ADDR_WIDTH+2)'(base) + (ADDR_WIDTH+2)'(len);
    assign reject    = (endAddr > (ADDR_WIDTH+2)'(DEPTH));
    assign bram_addr = base_q + issued_q[ADDR_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !zeroLen && !reject) state_d = RUN;
            RUN:     if (issue && lastIssue)           state_d = DRAIN;
            DRAIN:   if (pop && lastWord)              state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        accept = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zeroLen)     done_d = 1'b1;
                    else if (reject) err_d  = 1'b1;
                    else             accept = 1'b1;
                end
            end
            RUN:     issue  = credit;
            DRAIN:   done_d = pop && lastWord;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inFlight_q <= '0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                base_q   <= base;
                len_q    <= len;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) issued_q <= issued_q + (ADDR_WIDTH+1)'(1);
                if (pop)   popped_q <= popped_q + (ADDR_WIDTH+1)'(1);
            end
            case ({issue, retire})
                2'b10:   inFlight_q <= inFlight_q + 2'd1;
                2'b01:   inFlight_q <= inFlight_q - 2'd1;
                default: inFlight_q <= inFlight_q;
            endcase
        end
    end

    bram_skid_fifo #(
        .WIDTH (WIDTH)
    ) uSkid (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (bram_dout),
        .pop_i   (pop),
        .data_o  (out_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign bram_en   = issue;
    assign bram_we   = 1'b0;
    assign out_valid = !fifoEmpty;
    assign out_last  = out_valid && lastWord;

endmodule

// File: tb/tb_bram_reader.sv
// Scoreboard bench for bram_reader (WIDTH=8, DEPTH=16) against a behavioural BRAM model.
// Wrap-dependent expectations follow BRAM_READER_WRAP_EN.
module tb_bram_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [AW-1:0]    base      = '0;
    logic [AW:0]      len       = '0;
    logic             out_ready = 1'b1;
    logic             busy, done, err, bram_en, bram_we, bram_ready;
    logic             out_valid, out_last;
    logic [AW-1:0]    bram_addr;
    logic [WIDTH-1:0] bram_dout, out_data;

    int compared   = 0;
    int mismatched = 0;
    int cycleCnt   = 0;

    bram_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base       (base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_dout  (bram_dout),
        .bram_ready (bram_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural BRAM preloaded with mem[i] = i + 0x10, one cycle read latency.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] bramDoutReg  = '0;
    logic             bramReadyReg = 1'b0;
    logic             injectReady  = 1'b0;

    initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 'h10);

    always @(posedge clk) begin
        if (bram_en) bramDoutReg <= mem[bram_addr];
        bramReadyReg <= bram_en;
    end

    assign bram_dout  = bramDoutReg;
    assign bram_ready = bramReadyReg | injectReady;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entries are {last, data}.
    logic [8:0] expQ[$];
    bit monEn = 1'b0;
    int enCount, doneCount, errCount, popCount;
    int firstEnCycle, firstValidCycle, lastPopCycle, doneCycle, errCycle;
    bit busySeen;

    always @(negedge clk) begin
        if (monEn) begin
            if (bram_en) begin
                if (firstEnCycle < 0) firstEnCycle = cycleCnt;
                enCount++;
                checkOutput("bram_we_low", 32'(bram_we), 0);
            end
            if (busy) busySeen = 1'b1;
            if (done) begin
                doneCount++;
                doneCycle = cycleCnt;
                checkOutput("busy_low_at_done", 32'(busy), 0);
            end
            if (err) begin
                errCount++;
                errCycle = cycleCnt;
            end
            if (out_valid) begin
                if (firstValidCycle < 0) firstValidCycle = cycleCnt;
                checkOutput("sb_word_expected", 32'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    checkOutput("out_data", 32'(out_data), 32'(expQ[0][7:0]));
                    checkOutput("out_last", 32'(out_last), 32'(expQ[0][8]));
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        popCount++;
                        lastPopCycle = cycleCnt;
                    end
                end
            end
        end
    end

    task automatic clearStats();
        enCount = 0; doneCount = 0; errCount = 0; popCount = 0;
        firstEnCycle = -1; firstValidCycle = -1; lastPopCycle = -1;
        doneCycle = -1; errCycle = -1; busySeen = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input int b, input int l);
        for (int i = 0; i < l; i++) expQ.push_back({(i == l - 1), 8'(((b + i) % DEPTH) + 'h10)});
    endtask

    // Called #1 after a rising edge; kEdge is the cycle index right after the sampling edge.
    task automatic applyStimulus(input int b, input int l, output int kEdge);
        start = 1'b1;
        base  = AW'(b);
        len   = (AW+1)'(l);
        @(posedge clk);
        #1;
        kEdge = cycleCnt;
        start = 1'b0;
    endtask

    task automatic runUntilDone(input int readyMode, input int budget);
        int n = 0;
        while (doneCount == 0 && errCount == 0 && n < budget) begin
            out_ready = (readyMode == 0) ? 1'b1 : ((n % 3) == 0);
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("completion_in_budget", 32'(n < budget), 1);
        out_ready = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk);
        checkOutput(tag, 32'({busy, done, err, bram_en, out_valid, out_last}), 0);
        @(posedge clk);
        #1;
    endtask

    // A spurious bram_ready in the first cycle after release must not reach the FIFO.
    task automatic releaseReset();
        rst_n       = 1'b1;
        injectReady = 1'b1;
        @(posedge clk);
        #1;
        injectReady = 1'b0;
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        clearStats();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("por_outputs_zero");
        releaseReset();
        monEn = 1'b1;
        idleCycles(3);
        @(negedge clk);
        checkOutput("stale_ready_dropped", 32'(out_valid), 0);
        @(posedge clk);
        #1;

        $display("[TB] basic transfer base=2 len=4");
        clearStats();
        pushExpected(2, 4);
        applyStimulus(2, 4, k);
        runUntilDone(0, 40);
        idleCycles(2);
        checkOutput("a_first_en_cycle", 32'(firstEnCycle), 32'(k));
        checkOutput("a_first_valid_cycle", 32'(firstValidCycle), 32'(k + 2));
        checkOutput("a_last_pop_cycle", 32'(lastPopCycle), 32'(k + 5));
        checkOutput("a_done_cycle", 32'(doneCycle), 32'(k + 6));
        checkOutput("a_en_count", 32'(enCount), 4);
        checkOutput("a_pop_count", 32'(popCount), 4);
        checkOutput("a_done_count", 32'(doneCount), 1);
        checkOutput("a_sb_empty", 32'(expQ.size()), 0);

        $display("[TB] backpressure transfer base=2 len=4");
        clearStats();
        pushExpected(2, 4);
        applyStimulus(2, 4, k);
        runUntilDone(1, 60);
        idleCycles(2);
        checkOutput("b_en_count", 32'(enCount), 4);
        checkOutput("b_pop_count", 32'(popCount), 4);
        checkOutput("b_done_count", 32'(doneCount), 1);
        checkOutput("b_sb_empty", 32'(expQ.size()), 0);

        $display("[TB] zero-length transfer");
        clearStats();
        applyStimulus(5, 0, k);
        runUntilDone(0, 10);
        idleCycles(3);
        checkOutput("c_done_cycle", 32'(doneCycle), 32'(k));
        checkOutput("c_done_count", 32'(doneCount), 1);
        checkOutput("c_en_count", 32'(enCount), 0);
        checkOutput("c_busy_seen", 32'(busySeen), 0);

        $display("[TB] overrun transfer base=14 len=4");
        clearStats();
`ifdef BRAM_READER_WRAP_EN
        pushExpected(14, 4);
        applyStimulus(14, 4, k);
        runUntilDone(0, 40);
        idleCycles(2);
        checkOutput("d_en_count", 32'(enCount), 4);
        checkOutput("d_pop_count", 32'(popCount), 4);
        checkOutput("d_done_count", 32'(doneCount), 1);
        checkOutput("d_err_count", 32'(errCount), 0);
        checkOutput("d_sb_empty", 32'(expQ.size()), 0);
`else
        applyStimulus(14, 4, k);
        runUntilDone(0, 10);
        idleCycles(4);
        checkOutput("d_err_cycle", 32'(errCycle), 32'(k));
        checkOutput("d_err_count", 32'(errCount), 1);
        checkOutput("d_done_count", 32'(doneCount), 0);
        checkOutput("d_en_count", 32'(enCount), 0);
        checkOutput("d_busy_seen", 32'(busySeen), 0);
`endif

        $display("[TB] reset after second word, then base=0 len=2");
        clearStats();
        pushExpected(4, 6);
        applyStimulus(4, 6, k);
        for (int n = 0; n < 20 && popCount < 2; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("e_second_word_seen", 32'(popCount), 2);
        monEn = 1'b0;
        rst_n = 1'b0;
        checkResetOutputs("e_mid_reset_outputs_a");
        checkResetOutputs("e_mid_reset_outputs_b");
        expQ.delete();
        releaseReset();
        clearStats();
        monEn = 1'b1;
        idleCycles(1);
        pushExpected(0, 2);
        applyStimulus(0, 2, k);
        runUntilDone(0, 40);
        idleCycles(2);
        checkOutput("e_pop_count", 32'(popCount), 2);
        checkOutput("e_done_count", 32'(doneCount), 1);
        checkOutput("e_sb_empty", 32'(expQ.size()), 0);

        $display("[TB] start while busy is ignored");
        clearStats();
        pushExpected(8, 3);
        applyStimulus(8, 3, k);
        start = 1'b1;
        base  = AW'(0);
        len   = (AW+1)'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        runUntilDone(0, 40);
        idleCycles(6);
        checkOutput("f_en_count", 32'(enCount), 3);
        checkOutput("f_pop_count", 32'(popCount), 3);
        checkOutput("f_done_count", 32'(doneCount), 1);
        checkOutput("f_sb_empty", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
